spatial_window_gen: RTL and testbench
=====================================

SPATIAL_WINDOW_GEN -- requirements
Module: spatial_window_gen

Interface -- parameters
REQ-001 SHALL have DATA_WIDTH, default 16, pixel word width (Q8.8 signed).
REQ-002 SHALL have KERNEL_SIZE, default 3, window side length K (K >= 2).
REQ-003 SHALL have IMG_WIDTH, default 28, pixels per row W (W >= K).
REQ-004 SHALL have IMG_HEIGHT, default 28, rows per frame H (H >= K).

Interface -- ports
REQ-005 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have pixel_in, input, signed DATA_WIDTH, raster-order pixel.
REQ-008 SHALL have in_valid, input, 1, pixel_in is valid.
REQ-009 SHALL have in_ready, output, 1, block accepts pixel this cycle.
REQ-010 SHALL have window, output, unpacked array [K*K] of signed DATA_WIDTH; element K*i+j is window row i, column j, matching the kernel element order used by the conv kernel MAC.
REQ-011 SHALL have out_valid, output, 1, window holds a complete valid window.
REQ-012 SHALL have out_ready, input, 1, consumer takes window this cycle.
REQ-013 SHALL have frame_done, output, 1, one-cycle pulse when the last window of a frame is consumed.

Function
REQ-014 SHALL accept a pixel when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-015 SHALL track input position (row, col): col increments per accepted pixel, wraps W-1 -> 0 and increments row; row wraps H-1 -> 0 (no padding, valid convolution only).
REQ-016 SHALL store the previous K-1 rows in line buffers of W entries each, indexed by col, written on pixel accept.
REQ-017 SHALL shift a K x K register window left by one column per accepted pixel, the new right column being {oldest line buffer row ... newest line buffer row, pixel_in}; row 0 = oldest image row, column K-1 = newest pixel.
REQ-018 SHALL raise out_valid on the cycle after accepting a pixel with row >= K-1 and col >= K-1 (latency 1 cycle); window SHALL be stable while out_valid && !out_ready.
REQ-019 SHALL clear out_valid after a handshake (out_valid && out_ready) unless a new qualifying pixel is accepted the same cycle, in which case out_valid stays 1 with the new window.
REQ-020 SHALL produce exactly (H-K+1)*(W-K+1) windows per frame, in raster order.
REQ-021 SHALL hold all state when no pixel is accepted (in_valid low bubbles anywhere, including at row boundaries).
REQ-022 SHALL pulse frame_done in the cycle the window from input (H-1, W-1) is handshaken; next frame's pixels may be accepted in that same cycle.
REQ-023 SHALL ignore stale window columns after a row wrap; no window is emitted until col reaches K-1 again.
REQ-024 SHALL perform no arithmetic on pixel data; values pass through bit-exact.

Reset
REQ-025 SHALL, on rst, set row=0, col=0, out_valid=0, frame_done=0, all window registers to 0; line buffer contents need not be cleared.
REQ-026 SHALL treat rst mid-frame as frame abort: the next accepted pixel is (0,0); in_ready=1 in the cycle after reset.
REQ-027 SHALL give rst priority over any simultaneous handshake.

Structure
REQ-028 SHALL take default DATA_WIDTH, FRAC_WIDTH, KERNEL_SIZE constants from the shared cnn package also used by the conv kernel MAC and fixed_mult.
REQ-029 SHALL implement each line buffer as one sub-module, line_buffer (W-deep, one write and one read port at the same address, read-before-write), instantiated K-1 times in a chain.
REQ-030 SHALL use counter widths of $clog2 of IMG_WIDTH and IMG_HEIGHT.

Verification
REQ-031 SHALL check: W=H=4, K=3, pixels 0..15, out_ready=1 -> 4 windows; first = {0,1,2,4,5,6,8,9,10}, last = {5,6,7,9,10,11,13,14,15}; frame_done once.
REQ-032 SHALL check: out_ready held 0 for 5 cycles at first window -> in_ready=0, window unchanged, no pixel lost; windows match REQ-031 afterward.
REQ-033 SHALL check: random in_valid gaps (50%) on 28x28 frame -> 676 windows, each equal to the golden model.
REQ-034 SHALL check: rst asserted after 10 pixels -> out_valid=0, then a full 4x4 frame yields REQ-031 results.
REQ-035 SHALL check: two back-to-back 4x4 frames (second = pixel+100) -> 8 windows, second-frame first window {100,101,102,104,105,106,108,109,110}, two frame_done pulses.

Source files
------------

// File: rtl/spatial_window_gen_pkg.sv
// Shared CNN datapath constants.
// Imported by the window generator, the conv MAC and fixed_mult.
package spatial_window_gen_pkg;
  localparam int CNN_DATA_WIDTH  = 16;
  localparam int CNN_FRAC_WIDTH  = 8;
  localparam int CNN_KERNEL_SIZE = 3;
  localparam int CNN_IMG_WIDTH   = 28;
  localparam int CNN_IMG_HEIGHT  = 28;
endpackage

// File: rtl/spatial_window_gen_line_buffer.sv
// One image row of storage, indexed by column.
// Read returns the old word; the write lands at the clock edge.
module line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 28,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         i_wr_en,
  input  logic [AW-1:0]                i_addr,
  input  logic signed [DATA_WIDTH-1:0] i_wr_data,
  output logic signed [DATA_WIDTH-1:0] o_rd_data
);
  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Store the incoming word at its column on accept.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_addr];
endmodule

// File: rtl/spatial_window_gen.sv
// Sliding KxK window generator over a raster pixel stream.
// Valid-only convolution windows, one per qualifying pixel.
module spatial_window_gen
  import spatial_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
  parameter int KERNEL_SIZE = CNN_KERNEL_SIZE,
  parameter int IMG_WIDTH   = CNN_IMG_WIDTH,
  parameter int IMG_HEIGHT  = CNN_IMG_HEIGHT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] pixel_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] window [KERNEL_SIZE*KERNEL_SIZE],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_done
);
  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_out_valid;
  logic          r_last;

  logic signed [DATA_WIDTH-1:0] r_win [K][K];

  logic w_accept;
  logic w_qual;
  logic w_col_end;
  logic w_row_end;

  logic signed [DATA_WIDTH-1:0] w_lb_in  [K-1];
  logic signed [DATA_WIDTH-1:0] w_lb_out [K-1];
  logic signed [DATA_WIDTH-1:0] w_new_col [K];

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_col_end = (r_col == CW'(IMG_WIDTH-1));
  assign w_row_end = (r_row == RW'(IMG_HEIGHT-1));
  assign w_qual    = (r_row >= RW'(K-1)) &&
                     (r_col >= CW'(K-1));

  // Line buffer 0 holds the newest stored row,
  // buffer K-2 the oldest; each feeds the next.
  for (genvar g = 0; g < K-1; g++) begin : g_lb
    if (g == 0) begin : g_head
      assign w_lb_in[g] = pixel_in;
    end else begin : g_link
      assign w_lb_in[g] = w_lb_out[g-1];
    end

    line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .AW         (CW)
    ) u_lb (
      .clk       (clk),
      .i_wr_en   (w_accept),
      .i_addr    (r_col),
      .i_wr_data (w_lb_in[g]),
      .o_rd_data (w_lb_out[g])
    );
  end

  // Column entering the window: oldest row on top,
  // the live pixel at the bottom.
  for (genvar i = 0; i < K; i++) begin : g_col
    if (i == K-1) begin : g_pix
      assign w_new_col[i] = pixel_in;
    end else begin : g_buf
      assign w_new_col[i] = w_lb_out[K-2-i];
    end
    for (genvar j = 0; j < K; j++) begin : g_out
      assign window[K*i+j] = r_win[i][j];
    end
  end

  // Raster position; wraps at row end and frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Shift the window left one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K-1; j++) begin
          r_win[i][j] <= r_win[i][j+1];
        end
        r_win[i][K-1] <= w_new_col[i];
      end
    end
  end

  // Window valid flag; a new qualifying accept
  // in the handshake cycle keeps it high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= w_qual;
      r_last      <= w_row_end && w_col_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign frame_done = r_out_valid && out_ready && r_last;
endmodule

// File: tb/tb_spatial_window_gen.sv
// Bench for spatial_window_gen: 4x4 and 28x28 instances,
// scoreboard of expected windows plus constant tables.
`timescale 1ns/1ps
module tb_spatial_window_gen;
  typedef logic signed [15:0] win_t [9];
  typedef struct { win_t w; bit last; } exp_t;
  typedef struct { int idx; win_t exp; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic rst_s, vs, rdy_s, ov_s, ors, fd_s;
  logic signed [15:0] pxs;
  win_t win_s;

  logic rst_b, vb, rdy_b, ov_b, orb, fd_b;
  logic signed [15:0] pxb;
  win_t win_b;

  spatial_window_gen #(
    .DATA_WIDTH(16), .KERNEL_SIZE(3),
    .IMG_WIDTH(4), .IMG_HEIGHT(4)
  ) u_s (
    .clk(clk), .rst(rst_s), .pixel_in(pxs),
    .in_valid(vs), .in_ready(rdy_s), .window(win_s),
    .out_valid(ov_s), .out_ready(ors), .frame_done(fd_s)
  );

  spatial_window_gen #(
    .DATA_WIDTH(16), .KERNEL_SIZE(3),
    .IMG_WIDTH(28), .IMG_HEIGHT(28)
  ) u_b (
    .clk(clk), .rst(rst_b), .pixel_in(pxb),
    .in_valid(vb), .in_ready(rdy_b), .window(win_b),
    .out_valid(ov_b), .out_ready(orb), .frame_done(fd_b)
  );

  logic signed [15:0] img_s [4][4];
  logic signed [15:0] img_b [28][28];
  int mr_s = 0, mc_s = 0, mr_b = 0, mc_b = 0;
  exp_t q_s[$];
  exp_t q_b[$];
  win_t got_s[$];
  int fdc_s = 0, fdc_b = 0, cnt_b = 0;
  vec_t tbl [4];

  function automatic string w2s(input win_t w);
    string s = "{";
    for (int i = 0; i < 9; i++)
      s = {s, $sformatf("%0d%s", w[i], (i == 8) ? "}" : ",")};
    return s;
  endfunction

  function automatic bit win_eq(input win_t a, input win_t b);
    for (int i = 0; i < 9; i++)
      if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input string act, input string exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  task automatic model_s(input logic signed [15:0] px);
    exp_t e;
    img_s[mr_s][mc_s] = px;
    if (mr_s >= 2 && mc_s >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.w[3*i+j] = img_s[mr_s-2+i][mc_s-2+j];
      e.last = (mr_s == 3 && mc_s == 3);
      q_s.push_back(e);
    end
    if (mc_s == 3) begin
      mc_s = 0;
      mr_s = (mr_s == 3) ? 0 : mr_s + 1;
    end else mc_s++;
  endtask

  task automatic model_b(input logic signed [15:0] px);
    exp_t e;
    img_b[mr_b][mc_b] = px;
    if (mr_b >= 2 && mc_b >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.w[3*i+j] = img_b[mr_b-2+i][mc_b-2+j];
      e.last = (mr_b == 27 && mc_b == 27);
      q_b.push_back(e);
    end
    if (mc_b == 27) begin
      mc_b = 0;
      mr_b = (mr_b == 27) ? 0 : mr_b + 1;
    end else mc_b++;
  endtask

  task automatic send_s(input logic signed [15:0] px);
    int n = 0;
    vs = 1'b1;
    pxs = px;
    do begin @(negedge clk); n++; end
    while (!rdy_s && n < 300);
    if (!rdy_s) chk(1'b0, "s_accept_timeout", "stalled", "accept");
    else model_s(px);
    @(posedge clk); #1;
    vs = 1'b0;
  endtask

  task automatic send_b(input logic signed [15:0] px);
    int n = 0;
    vb = 1'b1;
    pxb = px;
    do begin @(negedge clk); n++; end
    while (!rdy_b && n < 300);
    if (!rdy_b) chk(1'b0, "b_accept_timeout", "stalled", "accept");
    else model_b(px);
    @(posedge clk); #1;
    vb = 1'b0;
  endtask

  task automatic drain_s();
    int n = 0;
    while (q_s.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk(q_s.size() == 0, "s_drain",
        $sformatf("%0d left", q_s.size()), "0 left");
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    int n = 0;
    while (q_b.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk(q_b.size() == 0, "b_drain",
        $sformatf("%0d left", q_b.size()), "0 left");
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input int base, input int start,
                             input string tag);
    win_t e;
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 9; m++)
        e[m] = tbl[k].exp[m] + 16'(base);
      if (start + tbl[k].idx < got_s.size())
        chk(win_eq(got_s[start+tbl[k].idx], e),
            $sformatf("%s_w%0d", tag, k),
            w2s(got_s[start+tbl[k].idx]), w2s(e));
      else
        chk(1'b0, $sformatf("%s_w%0d", tag, k), "missing", w2s(e));
    end
  endtask

  always @(negedge clk) begin : mon_s
    exp_t e;
    if (ov_s && ors && !rst_s) begin
      got_s.push_back(win_s);
      if (fd_s) fdc_s++;
      if (q_s.size() == 0) begin
        chk(1'b0, "s_extra_window", w2s(win_s), "none");
      end else begin
        e = q_s.pop_front();
        chk(win_eq(win_s, e.w), "s_window", w2s(win_s), w2s(e.w));
        chk(fd_s == e.last, "s_frame_done",
            $sformatf("%0b", fd_s), $sformatf("%0b", e.last));
      end
    end else if (fd_s) begin
      chk(1'b0, "s_stray_frame_done", "1", "0");
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (ov_b && orb && !rst_b) begin
      cnt_b++;
      if (fd_b) fdc_b++;
      if (q_b.size() == 0) begin
        chk(1'b0, "b_extra_window", w2s(win_b), "none");
      end else begin
        e = q_b.pop_front();
        chk(win_eq(win_b, e.w), "b_window", w2s(win_b), w2s(e.w));
        chk(fd_b == e.last, "b_frame_done",
            $sformatf("%0b", fd_b), $sformatf("%0b", e.last));
      end
    end else if (fd_b) begin
      chk(1'b0, "b_stray_frame_done", "1", "0");
    end
  end

  function automatic bit win_zero(input win_t w);
    for (int i = 0; i < 9; i++)
      if (w[i] !== 16'sd0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int raw [4][9] = '{
      '{0, 1, 2, 4, 5, 6, 8, 9, 10},
      '{1, 2, 3, 5, 6, 7, 9, 10, 11},
      '{4, 5, 6, 8, 9, 10, 12, 13, 14},
      '{5, 6, 7, 9, 10, 11, 13, 14, 15}
    };
    for (int k = 0; k < 4; k++) begin
      tbl[k].idx = k;
      for (int m = 0; m < 9; m++) tbl[k].exp[m] = 16'(raw[k][m]);
    end

    rst_s = 1'b1; rst_b = 1'b1;
    vs = 1'b0; vb = 1'b0; pxs = '0; pxb = '0;
    ors = 1'b1; orb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_s = 1'b0; rst_b = 1'b0;

    @(negedge clk);
    chk(ov_s == 1'b0, "rst_out_valid", $sformatf("%0b", ov_s), "0");
    chk(rdy_s == 1'b1, "rst_in_ready", $sformatf("%0b", rdy_s), "1");
    chk(fd_s == 1'b0, "rst_frame_done", $sformatf("%0b", fd_s), "0");
    chk(win_zero(win_s), "rst_window", w2s(win_s), "all 0");
    @(posedge clk); #1;

    // Basic frame, consumer always ready.
    got_s.delete(); fdc_s = 0;
    for (int p = 0; p < 16; p++) send_s(16'(p));
    drain_s();
    chk(got_s.size() == 4, "t1_count",
        $sformatf("%0d", got_s.size()), "4");
    check_frame(0, 0, "t1");
    chk(fdc_s == 1, "t1_fd_count", $sformatf("%0d", fdc_s), "1");

    // Consumer stalls on the first window.
    got_s.delete(); fdc_s = 0; ors = 1'b0;
    fork
      for (int p = 0; p < 16; p++) send_s(16'(p));
      begin : stall
        win_t snap;
        int n;
        n = 0;
        while (!ov_s && n < 200) begin @(negedge clk); n++; end
        chk(ov_s == 1'b1, "t2_first_valid", $sformatf("%0b", ov_s), "1");
        snap = win_s;
        repeat (5) begin
          @(negedge clk);
          chk(rdy_s == 1'b0, "t2_in_ready",
              $sformatf("%0b", rdy_s), "0");
          chk(win_eq(win_s, snap), "t2_hold", w2s(win_s), w2s(snap));
        end
        @(posedge clk); #1;
        ors = 1'b1;
      end
    join
    drain_s();
    chk(got_s.size() == 4, "t2_count",
        $sformatf("%0d", got_s.size()), "4");
    check_frame(0, 0, "t2");
    chk(fdc_s == 1, "t2_fd_count", $sformatf("%0d", fdc_s), "1");

    // Reset mid-frame with a window pending.
    got_s.delete(); fdc_s = 0; ors = 1'b0;
    for (int p = 0; p < 11; p++) send_s(16'(p));
    rst_s = 1'b1;
    @(posedge clk); #1;
    rst_s = 1'b0;
    q_s.delete(); mr_s = 0; mc_s = 0;
    @(negedge clk);
    chk(ov_s == 1'b0, "t3_out_valid", $sformatf("%0b", ov_s), "0");
    chk(rdy_s == 1'b1, "t3_in_ready", $sformatf("%0b", rdy_s), "1");
    chk(win_zero(win_s), "t3_window", w2s(win_s), "all 0");
    @(posedge clk); #1;
    ors = 1'b1;
    for (int p = 0; p < 16; p++) send_s(16'(p));
    drain_s();
    chk(got_s.size() == 4, "t3_count",
        $sformatf("%0d", got_s.size()), "4");
    check_frame(0, 0, "t3");
    chk(fdc_s == 1, "t3_fd_count", $sformatf("%0d", fdc_s), "1");

    // Two frames back to back.
    got_s.delete(); fdc_s = 0;
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 16; p++) send_s(16'(p + 100*f));
    drain_s();
    chk(got_s.size() == 8, "t4_count",
        $sformatf("%0d", got_s.size()), "8");
    check_frame(0, 0, "t4a");
    check_frame(100, 4, "t4b");
    chk(fdc_s == 2, "t4_fd_count", $sformatf("%0d", fdc_s), "2");

    // Full-size frame with random input bubbles.
    cnt_b = 0; fdc_b = 0;
    for (int p = 0; p < 784; p++) begin
      send_b(16'($urandom));
      if ($urandom_range(1, 0) == 1)
        repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
    end
    drain_b();
    chk(cnt_b == 676, "t5_count", $sformatf("%0d", cnt_b), "676");
    chk(fdc_b == 1, "t5_fd_count", $sformatf("%0d", fdc_b), "1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
